// File: rtl/neuron_seq.sv
// Dot-product sequencer for an external free-running MAC: feeds (x, w) pairs, snapshots the
// accumulator per neuron, then applies bias / ReLU / shift / saturation and hands the result downstream.
//
// state | meaning
// IDLE  | waiting for the first pair; base tracks the (stable) accumulator
// ACCUM | streaming pairs of the current neuron into the MAC
// DRAIN | MAC is summing the final pair
// CALC  | accumulator final; post-process and register the result
// OUT   | result presented, waiting for res_ready
module neuron_seq #(
    parameter int MAX_LEN = 16,
    parameter int BIAS    = 0,
    parameter int SHIFT   = 0,
    parameter int RELU    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_x,
    input  logic [7:0]  in_w,
    input  logic        in_last,
    output logic [7:0]  mac_x,
    output logic [7:0]  mac_weight,
    input  logic [15:0] mac_out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [7:0]  res_data,
    output logic        res_trunc
);

    localparam int CW = $clog2(MAX_LEN + 1);
    localparam logic [CW-1:0] LEN_LIM = CW'(MAX_LEN);
    localparam logic signed [16:0] BIAS17 = 17'(BIAS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DRAIN,
        ST_CALC,
        ST_OUT
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        mac_x_q, mac_x_d;
    logic [7:0]        mac_weight_q, mac_weight_d;
    logic [15:0]       base_q, base_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     count_inc;
    logic              trunc_q, trunc_d;
    logic              res_valid_q, res_valid_d;
    logic [7:0]        res_data_q, res_data_d;
    logic              res_trunc_q, res_trunc_d;

    logic              accept;
    logic [15:0]       dot;
    logic signed [16:0] biased;
    logic signed [16:0] rectified;
    logic signed [16:0] shifted;
    logic [7:0]        sat;

    assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_ACCUM);
    assign accept    = in_valid && in_ready;
    assign count_inc = count_q + CW'(1);

    // The MAC never clears, so the neuron's contribution is the delta since the snapshot.
    assign dot       = mac_out - base_q;
    assign biased    = $signed({dot[15], dot}) + BIAS17;
    assign rectified = ((RELU != 0) && biased[16]) ? '0 : biased;
    assign shifted   = rectified >>> SHIFT;

    always_comb begin
        if (shifted > 17'sd127) begin
            sat = 8'h7f;
        end else if (shifted < -17'sd128) begin
            sat = 8'h80;
        end else begin
            sat = shifted[7:0];
        end
    end

    always_comb begin
        state_d      = state_q;
        mac_x_d      = '0;
        mac_weight_d = '0;
        base_d       = base_q;
        count_d      = count_q;
        trunc_d      = trunc_q;
        res_valid_d  = res_valid_q;
        res_data_d   = res_data_q;
        res_trunc_d  = res_trunc_q;

        if (accept) begin
            mac_x_d      = in_x;
            mac_weight_d = in_w;
        end

        case (state_q)
            ST_IDLE: begin
                base_d = mac_out;
                if (accept) begin
                    count_d = count_inc;
                    if (in_last || (count_inc == LEN_LIM)) begin
                        state_d = ST_DRAIN;
                        trunc_d = !in_last;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end
            end
            ST_ACCUM: begin
                if (accept) begin
                    count_d = count_inc;
                    if (in_last || (count_inc == LEN_LIM)) begin
                        state_d = ST_DRAIN;
                        trunc_d = !in_last;
                    end
                end
            end
            ST_DRAIN: begin
                state_d = ST_CALC;
            end
            ST_CALC: begin
                res_data_d  = sat;
                res_trunc_d = trunc_q;
                res_valid_d = 1'b1;
                state_d     = ST_OUT;
            end
            ST_OUT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    count_d     = '0;
                    trunc_d     = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            mac_x_q      <= '0;
            mac_weight_q <= '0;
            base_q       <= '0;
            count_q      <= '0;
            trunc_q      <= 1'b0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_trunc_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            mac_x_q      <= mac_x_d;
            mac_weight_q <= mac_weight_d;
            base_q       <= base_d;
            count_q      <= count_d;
            trunc_q      <= trunc_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_trunc_q  <= res_trunc_d;
        end
    end

    assign mac_x      = mac_x_q;
    assign mac_weight = mac_weight_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_trunc  = res_trunc_q;

endmodule

// File: doc/neuron_seq.md
Name: neuron_seq

Overview:
- Initiator/reader for the `mac` accumulator: streams (x, weight) pairs into the MAC and reads back its running total.
- The MAC has no clear, so the block snapshots the accumulator at the start of each neuron. It produces the per-neuron dot product as `mac_out - snapshot`.
- Applies bias, optional ReLU, arithmetic right shift and saturation to signed 8-bit.
- Presents the result on a valid/ready output toward the next layer.

Parameters:
- MAX_LEN, 16: maximum pairs per neuron; the neuron is force-terminated on reaching it.
- BIAS, 0: signed 16-bit bias added to the dot product.
- SHIFT, 0: arithmetic right-shift amount (0..8) applied after the bias.
- RELU, 1: 1 = clamp negative values to 0 before the shift; 0 = pass negatives through.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset; shared with the MAC
- in_valid  in  1  input pair valid
- in_ready  out  1  block accepts a pair this cycle
- in_x  in  8  signed activation
- in_w  in  8  signed weight
- in_last  in  1  marks the final pair of a neuron
- mac_x  out  8  signed, registered, to MAC x
- mac_weight  out  8  signed, registered, to MAC weight
- mac_out  in  16  signed MAC accumulator
- res_valid  out  1  result valid
- res_ready  in  1  downstream accepts the result
- res_data  out  8  signed saturated result
- res_trunc  out  1  neuron was terminated by MAX_LEN, not by in_last

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low on rst_n.
- Reset values: state IDLE; mac_x = 0, mac_weight = 0, res_valid = 0, res_data = 0, res_trunc = 0; base = 0; count = 0.
- in_ready is combinational: 1 in IDLE and ACCUM, 0 otherwise.
- Accept = in_valid & in_ready.
- On accept, mac_x/mac_weight <= in_x/in_w. On every other cycle they are <= 0, so the MAC holds its value.
- FSM states:
  - IDLE: base <= mac_out every cycle (stable, because mac_x = 0).
    - Accept with in_last, or count+1 == MAX_LEN -> DRAIN.
    - Otherwise accept -> ACCUM, count <= 1.
  - ACCUM: accept increments count.
    - Accept with in_last -> DRAIN.
    - Accept with count+1 == MAX_LEN -> DRAIN with trunc flag set.
    - Gaps (in_valid low) allowed; MAC sees zeros during gaps.
  - DRAIN: exactly 1 cycle; the last pair is being summed by the MAC. -> CALC.
  - CALC: mac_out is final.
    - dot = mac_out - base, 16-bit wrap-around (matches MAC wrap).
    - s = sign-extend(dot, 17) + sign-extend(BIAS, 17), no wrap.
    - If RELU and s < 0, s = 0.
    - s = s >>> SHIFT.
    - res_data <= clamp(s, -128, 127).
    - res_trunc <= trunc flag; res_valid <= 1 -> OUT.
  - OUT: res_data and res_trunc held stable while res_valid = 1.
    - On res_valid & res_ready: res_valid <= 0, count <= 0, trunc flag cleared -> IDLE.
    - in_ready = 0 throughout OUT (backpressure).
- Latency: last accept at edge E -> DRAIN after E -> CALC after E+1 -> res_valid = 1 after E+2.
- Minimum neuron period (single pair, res_ready = 1) is 4 cycles: IDLE, DRAIN, CALC, OUT.
- Single-pair neuron (first pair also last) goes IDLE -> DRAIN directly.
- MAX_LEN = 1 means every pair terminates a neuron. res_trunc = 1 only if in_last was 0 on that pair.
- When in_last and the MAX_LEN limit coincide, res_trunc = 0.
- A pair arriving in the cycle after forced termination is not accepted until the next IDLE; it starts a new neuron.
- Reset mid-operation (any state): all outputs return to reset values immediately, state -> IDLE. The MAC resets to 0 simultaneously, so base = 0 stays consistent.
- Accumulator wrap: a dot product beyond ±32767 wraps (MAC behaviour). No detection is required.

Test Plan:
- RELU=0, BIAS=0, SHIFT=0: pairs (3,4), (-2,5), (7,-1, last) -> res_valid exactly 2 cycles after last accept, res_data = -5, res_trunc = 0.
- Back-to-back neurons (MAC holds -5 from the previous one): next neuron (10,10, last) -> dot = 100, res_data = 100. Then (20,20, last) -> 400, saturates to 127.
- RELU=1, BIAS=-6, SHIFT=1: pairs (4,2), (1,1, last) -> 9-6 = 3, >>>1 = 1. Pairs (1,1, last) -> -5 clamped to 0.
- res_ready held low 5 cycles in OUT -> res_data/res_trunc stable, in_ready = 0, mac_x = 0 throughout. Handshake then returns to IDLE in 1 cycle.
- MAX_LEN=4: six pairs (1,1) with no in_last -> first result 4 with res_trunc = 1. Remaining pairs form a second neuron; the pair marked last gives 2 with res_trunc = 0.
- rst_n low during ACCUM after 2 pairs -> all outputs 0, IDLE; next neuron (2,3, last) -> res_data = 6.
